// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues ROM reads from the PC stage and buffers up to
// two {pc, inst} pairs toward decode, with flush and stall handling.
module ifetch_queue (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pc,
  input  logic        ce,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] rom_data,
  output logic        rom_ce,
  output logic [9:0]  rom_addr,
  output logic        id_valid,
  output logic [11:0] id_pc,
  output logic [31:0] id_inst,
  output logic        stall_req
);

  localparam int unsigned PcW   = 12;
  localparam int unsigned InstW = 32;
  localparam int unsigned AddrW = 10;
  localparam int unsigned Depth = 2;
  localparam int unsigned CntW  = 2;

  localparam logic [CntW-1:0]  CntFull = CntW'(Depth);
  localparam logic [CntW-1:0]  CntOne  = CntW'(1);
  localparam logic [InstW-1:0] NopInst = 32'h0000_0013;

  typedef struct packed {
    logic [PcW-1:0]   pc;
    logic [InstW-1:0] inst;
  } entry_t;

  entry_t          mem [Depth];
  logic            req_valid;
  logic [PcW-1:0]  req_pc;
  logic            wr_ptr;
  logic            rd_ptr;
  logic [CntW-1:0] count;
  logic            push;
  logic            pop;

  // Byte-offset bits and the stall bits owned by later stages are not used here.
  logic unused_bits;
  assign unused_bits = ^{stall[5:2], pc[1:0]};

  // Fetch issue, head presentation and push/pop qualification.
  always_comb begin
    stall_req = (count == CntFull) | ((count == CntOne) & req_valid);
    rom_ce    = ce & ~stall[0] & ~flush & ~stall_req;
    rom_addr  = pc[PcW-1:PcW-AddrW];
    id_valid  = (count != '0);
    id_pc     = '0;
    id_inst   = NopInst;
    if (id_valid) begin
      id_pc   = mem[rd_ptr].pc;
      id_inst = mem[rd_ptr].inst;
    end
    push = req_valid & ~flush;
    pop  = id_valid & ~stall[1] & ~flush;
  end

  // Control state; flush clears everything and wins over push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      req_valid <= 1'b0;
      count     <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
    end else begin
      req_valid <= rom_ce;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + CntOne;
        2'b01:   count <= count - CntOne;
        default: count <= count;
      endcase
    end
  end

  // PC of the outstanding ROM read; only meaningful while req_valid is set.
  always_ff @(posedge clk) begin
    if (rom_ce) req_pc <= pc;
  end

  // Entry storage needs no reset: count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= '{pc: req_pc, inst: rom_data};
  end

endmodule
